// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline payload types and constants for the inter-stage registers
package pipe_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } fd_bundle_t;
  localparam int FD_WIDTH = $bits(fd_bundle_t);
  localparam logic [FD_WIDTH-1:0] FD_CLEAR = {NOP_INSTR, 64'h0};
endpackage

// File: rtl/pipe_data_reg.sv
// pipe_data_reg: payload register that loads only on transfer and returns to CLEAR_VAL on clear
module pipe_data_reg #(
  parameter int                 WIDTH     = 96,
  parameter logic [WIDTH-1:0]   CLEAR_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // clear beats load so a killed or emptied entry always reads as a bubble
  always_ff @(posedge clk) begin
    if (reset || clear) q <= CLEAR_VAL;
    else if (load)      q <= d;
  end
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic valid/ready pipeline register with optional skid entry and flush
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = FD_WIDTH,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0,
  parameter bit               SKID_EN   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);
  logic             main_valid_q, main_valid_d, skid_valid_q;
  logic             accept, drain, main_load, main_clear;
  logic [WIDTH-1:0] main_d, skid_q;
  assign accept     = in_valid & in_ready & ~flush;
  assign drain      = main_valid_q & out_ready;
  assign out_valid  = main_valid_q;
  assign occupancy  = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
  // a held skid entry has priority into main; otherwise main takes the new payload when free
  assign main_load  = ~flush & (skid_valid_q ? drain : accept & (~main_valid_q | drain));
  assign main_d     = skid_valid_q ? skid_q : in_data;
  assign main_clear = flush | (drain & ~main_load);
  assign main_valid_d = ~flush & (main_load | (main_valid_q & ~drain));
  // main entry valid flag
  always_ff @(posedge clk) begin
    if (reset) main_valid_q <= 1'b0;
    else       main_valid_q <= main_valid_d;
  end
  pipe_data_reg #(.WIDTH(WIDTH), .CLEAR_VAL(CLEAR_VAL)) u_main (
    .clk(clk), .reset(reset), .clear(main_clear), .load(main_load), .d(main_d), .q(out_data)
  );
  generate
    if (SKID_EN) begin : g_skid
      logic skid_valid_d, skid_load;
      assign in_ready     = ~skid_valid_q;
      assign skid_load    = accept & main_valid_q & ~drain;
      assign skid_valid_d = ~flush & (skid_load | (skid_valid_q & ~drain));
      // skid entry valid flag; its inverse is the registered in_ready
      always_ff @(posedge clk) begin
        if (reset) skid_valid_q <= 1'b0;
        else       skid_valid_q <= skid_valid_d;
      end
      pipe_data_reg #(.WIDTH(WIDTH), .CLEAR_VAL(CLEAR_VAL)) u_skid (
        .clk(clk), .reset(reset), .clear(flush | (skid_valid_q & drain)), .load(skid_load),
        .d(in_data), .q(skid_q)
      );
    end else begin : g_bypass
      assign in_ready     = ~main_valid_q | out_ready;
      assign skid_valid_q = 1'b0;
      assign skid_q       = CLEAR_VAL;
    end
  endgenerate
endmodule
